// File: rtl/compare_8_serial_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// State encodings and default operand width.
package compare_8_serial_pkg;

  localparam int CMP_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/compare_8_serial_bit_counter.sv
// Saturating beat counter for the serial comparator.
// Flags the beat that completes a WIDTH-bit operand.
module compare_8_serial_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q != CW'(WIDTH)))
      count_d = count_q + CW'(1);
  end

  assign last = inc && (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/compare_8_serial.sv
// Bit-serial unsigned comparator: operands arrive MSB first,
// one bit pair per accepted beat; results pulse out with done.
module compare_8_serial
  import compare_8_serial_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic in_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic ready,
  output logic busy,
  output logic done,
  output logic equal,
  output logic a_gt_b,
  output logic a_lt_b
);

  state_e state_q, state_d;
  logic   decided_q, decided_d;
  logic   dgt_q, dgt_d;
  logic   dlt_q, dlt_d;
  logic   done_q, done_d;
  logic   eq_q, eq_d;
  logic   gt_q, gt_d;
  logic   lt_q, lt_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

  compare_8_serial_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  // The running decision is kept apart from the visible
  // results so the outputs stay 0 until done.
  always_comb begin
    state_d   = state_q;
    decided_d = decided_q;
    dgt_d     = dgt_q;
    dlt_d     = dlt_q;
    done_d    = 1'b0;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_SHIFT;
          cnt_clr   = 1'b1;
          decided_d = 1'b0;
          dgt_d     = 1'b0;
          dlt_d     = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d   = S_IDLE;
          cnt_clr   = 1'b1;
          decided_d = 1'b0;
          dgt_d     = 1'b0;
          dlt_d     = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end else if (in_valid) begin
          cnt_inc = 1'b1;
          if (!decided_q && (a_bit != b_bit)) begin
            decided_d = 1'b1;
            dgt_d     = a_bit;
            dlt_d     = b_bit;
          end
          if (cnt_last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            eq_d    = ~decided_d;
            gt_d    = dgt_d;
            lt_d    = dlt_d;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      decided_q <= 1'b0;
      dgt_q     <= 1'b0;
      dlt_q     <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      decided_q <= decided_d;
      dgt_q     <= dgt_d;
      dlt_q     <= dlt_d;
      done_q    <= done_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign ready  = (state_q == S_SHIFT);
  assign busy   = (state_q == S_SHIFT);
  assign done   = done_q;
  assign equal  = eq_q;
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;

endmodule

// File: tb/tb_compare_8_serial.sv
// Directed bench for the bit-serial comparator.
// Hand-computed expectations checked with immediate assertions.
module tb_compare_8_serial;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic abort;
  logic in_valid;
  logic a_bit;
  logic b_bit;
  logic ready;
  logic busy;
  logic done;
  logic equal;
  logic a_gt_b;
  logic a_lt_b;

  int checks   = 0;
  int failures = 0;
  int ncyc;

  always #5 clk = ~clk;

  compare_8_serial dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .in_valid(in_valid),
    .a_bit   (a_bit),
    .b_bit   (b_bit),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .equal   (equal),
    .a_gt_b  (a_gt_b),
    .a_lt_b  (a_lt_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs,
                         input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_done,
                         input logic e_eq, input logic e_gt,
                         input logic e_lt, input logic e_busy);
    chk({tag, ".done"}, done, e_done);
    chk({tag, ".equal"}, equal, e_eq);
    chk({tag, ".gt"}, a_gt_b, e_gt);
    chk({tag, ".lt"}, a_lt_b, e_lt);
    chk({tag, ".busy"}, busy, e_busy);
    chk({tag, ".ready"}, ready, e_busy);
  endtask

  // Send bits hi downto lo of a/b, one beat per cycle.
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      in_valid = 1'b1;
      a_bit    = a[i];
      b_bit    = b[i];
      tick();
    end
    in_valid = 1'b0;
    a_bit    = 1'b0;
    b_bit    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    a_bit    = 1'b0;
    b_bit    = 1'b0;
    ncyc     = 0;
    tick();
    tick();
    chk_out("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // 1: 00 vs 00, back-to-back, done 9 cycles after start
    ncyc = 0;
    do_start();
    chk_out("t1.shift", 0, 0, 0, 0, 1);
    send(8'h00, 8'h00, 7, 1);
    chk("t1.early_done", done, 1'b0);
    send(8'h00, 8'h00, 0, 0);
    chk_int("t1.latency", ncyc, 9);
    chk_out("t1.done", 1, 1, 0, 0, 0);
    tick();
    chk_out("t1.hold", 0, 1, 0, 0, 0);

    // 2: 3C vs 5A -> lt decided at bit 6
    do_start();
    chk("t2.cleared_eq", equal, 1'b0);
    send(8'h3C, 8'h5A, 7, 6);
    chk_out("t2.mid", 0, 0, 0, 0, 1);
    send(8'h3C, 8'h5A, 5, 0);
    chk_out("t2.done", 1, 0, 0, 1, 0);

    // 3: BC vs 5A -> gt at MSB, later bits don't flip
    do_start();
    send(8'hBC, 8'h5A, 7, 0);
    chk_out("t3.done", 1, 0, 1, 0, 0);

    // 4: 3C vs 3C with 3 stall cycles after beat 4
    do_start();
    send(8'h3C, 8'h3C, 7, 4);
    tick();
    tick();
    tick();
    chk_out("t4.stall", 0, 0, 0, 0, 1);
    send(8'h3C, 8'h3C, 3, 1);
    chk("t4.early_done", done, 1'b0);
    send(8'h3C, 8'h3C, 0, 0);
    chk_out("t4.done", 1, 1, 0, 0, 0);
    tick();

    // abort in DONE keeps held results
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("t5.abort_done", 0, 1, 0, 0, 0);

    // 5: abort after beat 5
    do_start();
    send(8'hF0, 8'h0F, 7, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("t5.abort", 0, 0, 0, 0, 0);
    tick();
    chk("t5.no_done", done, 1'b0);

    // in_valid in IDLE is ignored
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("t5.idle_valid", 0, 0, 0, 0, 0);

    // start+abort together in SHIFT: abort wins
    do_start();
    send(8'h00, 8'h00, 7, 6);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_out("t5.start_abort", 0, 0, 0, 0, 0);

    // start in SHIFT ignored: count continues
    do_start();
    send(8'h01, 8'h00, 7, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5.start_shift_busy", busy, 1'b1);
    send(8'h01, 8'h00, 4, 0);
    chk_out("t5.start_ignored", 1, 0, 1, 0, 0);

    // 6: reset mid-operation after beat 3
    do_start();
    send(8'h00, 8'hFF, 7, 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("t6.reset", 0, 0, 0, 0, 0);

    // start with in_valid same cycle: that beat is dropped
    start    = 1'b1;
    in_valid = 1'b1;
    a_bit    = 1'b1;
    b_bit    = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    send(8'hFF, 8'hFE, 7, 1);
    chk("t6.early_done", done, 1'b0);
    chk("t6.busy_lsb", busy, 1'b1);
    send(8'hFF, 8'hFE, 0, 0);
    chk_out("t6.done", 1, 0, 1, 0, 0);

    // in_valid on done cycle ignored; start in DONE restarts
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("t6.valid_in_done", 0, 0, 1, 0, 0);
    do_start();
    chk_out("t6.restart", 0, 0, 0, 0, 1);
    send(8'h7E, 8'h7E, 7, 0);
    chk_out("t6.rerun", 1, 1, 0, 0, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
